// File: rtl/max_seq_pkg.sv
// Shared definitions for the max_seq reducer: project-wide default widths
// and the two-state FSM encoding.
package max_seq_pkg;

   // Project defaults for the streaming reducers.
   localparam int NUM_WIDTH_DEF   = 16;
   localparam int INDEX_WIDTH_DEF = 4;
   localparam int OUTPUT_SIZE_DEF = 10;

   // ACC: accepting elements of a vector. OUT: holding a finished result.
   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

endpackage

// File: rtl/max_seq_cmp_sel.sv
// cmp_sel_comb: decides whether candidate a replaces the current extreme b.
// Signed strict comparison, so ties keep the incumbent (lowest index wins).
module cmp_sel_comb #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         mode,
   output logic         take_a
);

   // mode 0 looks for the maximum, mode 1 for the minimum.
   always_comb begin
      take_a = mode ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
   end

endmodule

// File: rtl/max_seq.sv
// max_seq: streaming argmax/argmin over vectors of LENGTH signed elements.
// Handshake: an element moves when in_valid && in_ready at a rising edge,
// a result moves when out_valid && out_ready at a rising edge. in_ready and
// out_valid are registered, so neither depends combinationally on inputs.
module max_seq
   import max_seq_pkg::*;
#(
   parameter int NUM_WIDTH   = NUM_WIDTH_DEF,
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
   parameter int LENGTH      = OUTPUT_SIZE_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_WIDTH-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_WIDTH-1:0]   out_val,
   output logic [INDEX_WIDTH-1:0] out_pos,
   output state_t                 fsm_state
);

   // Index of the final element of a vector.
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LENGTH - 1);

   logic [NUM_WIDTH-1:0]   best;
   logic [INDEX_WIDTH-1:0] pos;
   logic [INDEX_WIDTH-1:0] idx;
   logic                   mode_q;
   logic                   take;
   logic                   accept;
   logic                   release_res;

   assign accept      = in_valid && in_ready;
   assign release_res = out_valid && out_ready;

   cmp_sel_comb #(
      .W(NUM_WIDTH)
   ) u_cmp (
      .a      (in_data),
      .b      (best),
      .mode   (mode_q),
      .take_a (take)
   );

   // FSM with registered handshake outputs and the running extreme.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_state <= ST_ACC;
         idx       <= '0;
         best      <= '0;
         pos       <= '0;
         mode_q    <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (fsm_state)
            ST_ACC: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               if (accept) begin
                  if (idx == '0) begin
                     // First element seeds the result and latches the mode.
                     best   <= in_data;
                     pos    <= '0;
                     mode_q <= mode;
                  end else if (take) begin
                     best <= in_data;
                     pos  <= idx;
                  end
                  if (idx == LAST_IDX) begin
                     idx       <= '0;
                     fsm_state <= ST_OUT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     idx <= idx + INDEX_WIDTH'(1);
                  end
               end
            end
            ST_OUT: begin
               // Result held until taken; no bypass into the next vector.
               if (release_res) begin
                  fsm_state <= ST_ACC;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               fsm_state <= ST_ACC;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_val = best;
   assign out_pos = pos;

endmodule
